fsm_stim_driver: RTL



---
 rtl/fsm_stim_driver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fsm_stim_driver.sv
// Command-driven stimulus/check engine for a 2-input, 2-bit-state control FSM.
// Optional saturating mismatch counter on err_cnt: define FSM_STIM_ERR_CNT_EN.
module fsm_stim_driver #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned CHK_SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_a,
    input  logic             cmd_b,
    input  logic             cmd_rst,
    input  logic [CNT_W-1:0] cmd_hold,
    input  logic             cmd_chk,
    input  logic [1:0]       cmd_exp,
    output logic             tgt_a,
    output logic             tgt_b,
    output logic             tgt_reset,
    input  logic [1:0]       tgt_state,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_pass,
    output logic [1:0]       rsp_state
`ifdef FSM_STIM_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned SET_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               chk_q, chk_d;
    logic [1:0]         exp_q, exp_d;
    logic               cmd_ready_d;
    logic               tgt_a_d, tgt_b_d, tgt_reset_d;
    logic               rsp_valid_d, rsp_pass_d;
    logic [1:0]         rsp_state_d;
    logic               accept_c;
    logic               mismatch_c;
    logic               sample_c;

    assign accept_c   = cmd_valid && cmd_ready;
    assign mismatch_c = chk_q && (tgt_state != exp_q);

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        settle_d    = settle_q;
        chk_d       = chk_q;
        exp_d       = exp_q;
        tgt_a_d     = tgt_a;
        tgt_b_d     = tgt_b;
        tgt_reset_d = tgt_reset;
        rsp_valid_d = rsp_valid;
        rsp_pass_d  = rsp_pass;
        rsp_state_d = rsp_state;
        sample_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    hold_d      = (cmd_hold == '0) ? CNT_W'(1) : cmd_hold;
                    chk_d       = cmd_chk;
                    exp_d       = cmd_exp;
                    tgt_a_d     = cmd_a;
                    tgt_b_d     = cmd_b;
                    tgt_reset_d = cmd_rst;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q <= CNT_W'(1)) begin
                    tgt_reset_d = 1'b0;
                    settle_d    = SET_W'(CHK_SETTLE - 1);
                    state_d     = SETTLE;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    sample_c    = 1'b1;
                    rsp_state_d = tgt_state;
                    rsp_pass_d  = !mismatch_c;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            settle_q  <= '0;
            chk_q     <= 1'b0;
            exp_q     <= '0;
            cmd_ready <= 1'b0;
            tgt_a     <= 1'b0;
            tgt_b     <= 1'b0;
            tgt_reset <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_pass  <= 1'b0;
            rsp_state <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            settle_q  <= settle_d;
            chk_q     <= chk_d;
            exp_q     <= exp_d;
            cmd_ready <= cmd_ready_d;
            tgt_a     <= tgt_a_d;
            tgt_b     <= tgt_b_d;
            tgt_reset <= tgt_reset_d;
            rsp_valid <= rsp_valid_d;
            rsp_pass  <= rsp_pass_d;
            rsp_state <= rsp_state_d;
        end
    end

`ifdef FSM_STIM_ERR_CNT_EN
    // Saturating mismatch counter, updated on the response-launch edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (sample_c && mismatch_c && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
